// File: rtl/multiplier_pkg.sv
// Shared state type and elaboration helpers for the multiplier sequencer.
// The sequencer's optional early-exit feature is selected by MULTIPLIER_EARLY_EXIT_EN.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } multiplier_state_t;

  function automatic bit step_is_legal(input int n, input int step);
    return ((step == 1) || (step == 2) || (step == 4)) && (n > 0) && ((n % step) == 0);
  endfunction

  // Width of the iteration counter: max(1, clog2(iter)).
  function automatic int count_width(input int iter);
    return (iter <= 2) ? 1 : $clog2(iter);
  endfunction

endpackage

// File: rtl/multiplier_iter_counter.sv
// C-bit iteration down-counter with preset; saturates at zero instead of wrapping.
module multiplier_iter_counter #(
  parameter int C = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         preset,
  input  logic [C-1:0] preset_value,
  input  logic         decrement,
  output logic [C-1:0] value,
  output logic         is_zero
);

  assign is_zero = (value == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (preset) begin
      value <= preset_value;
    end else if (decrement && !is_zero) begin
      value <= value - C'(1);
    end
  end

endmodule

// File: rtl/multiplier_sequencer.sv
// Control sequencer for an iterative multiplier: IDLE -> LOAD -> RUN x ITER -> DONE.
// Define MULTIPLIER_EARLY_EXIT_EN to let remaining_zero end RUN early.
module multiplier_sequencer
  import multiplier_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int STEP = 1,
  localparam int ITER = (STEP > 0) ? (N / STEP) : 1,
  localparam int C    = count_width(ITER)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         remaining_zero,
  output logic         busy,
  output logic         do_load,
  output logic         do_step,
  output logic         last_step,
  output logic         done,
  output logic [C-1:0] count
);

  if (!step_is_legal(N, STEP)) begin : g_bad_step
    $error("multiplier_sequencer: STEP must be 1, 2 or 4 and must divide N");
  end

  multiplier_state_t state;
  logic              early_exit;
  logic              count_is_zero;

`ifdef MULTIPLIER_EARLY_EXIT_EN
  assign early_exit = remaining_zero;
`else
  logic unused_remaining_zero;
  assign unused_remaining_zero = remaining_zero;
  assign early_exit            = 1'b0;
`endif

  // Strobes are decoded from state so abort and early exit can veto them in the same cycle.
  assign busy      = (state != IDLE);
  assign do_load   = (state == LOAD) && !abort;
  assign do_step   = (state == RUN) && !abort && !early_exit;
  assign last_step = do_step && count_is_zero;
  assign done      = (state == DONE) && !abort;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= LOAD;
        LOAD:    state <= RUN;
        RUN:     if (early_exit || count_is_zero) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  multiplier_iter_counter #(
    .C(C)
  ) u_iter_counter (
    .clock        (clock),
    .reset        (reset),
    .preset       (do_load),
    .preset_value (C'(ITER - 1)),
    .decrement    (do_step),
    .value        (count),
    .is_zero      (count_is_zero)
  );

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Bench for multiplier_sequencer: three configurations (ITER 8, 4, 1) driven in lockstep
// and compared every cycle against a phase-based reference model.
module tb_multiplier_sequencer;

`ifdef MULTIPLIER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int ITERS [3] = '{8, 4, 1};

  // ---------------- clock / reset / DUTs ----------------
  logic clock = 1'b0;
  logic reset, start, abort, remaining_zero;
  logic busy [3], do_load [3], do_step [3], last_step [3], done [3];
  logic [2:0] count0;
  logic [1:0] count1;
  logic [0:0] count2;

  always #5 clock = ~clock;

  multiplier_sequencer #(.N(8), .STEP(1)) dut0 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .remaining_zero(remaining_zero),
    .busy(busy[0]), .do_load(do_load[0]), .do_step(do_step[0]), .last_step(last_step[0]),
    .done(done[0]), .count(count0));
  multiplier_sequencer #(.N(8), .STEP(2)) dut1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .remaining_zero(remaining_zero),
    .busy(busy[1]), .do_load(do_load[1]), .do_step(do_step[1]), .last_step(last_step[1]),
    .done(done[1]), .count(count1));
  multiplier_sequencer #(.N(4), .STEP(4)) dut2 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .remaining_zero(remaining_zero),
    .busy(busy[2]), .do_load(do_load[2]), .do_step(do_step[2]), .last_step(last_step[2]),
    .done(done[2]), .count(count2));

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 load, 2..ITER+1 run, ITER+2 done. cnt: expected count value.
  int phase [3];
  int cnt [3];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] observed(input int i);
    logic [2:0] c;
    c = (i == 0) ? count0 : (i == 1) ? {1'b0, count1} : {2'b00, count2};
    return {busy[i], do_load[i], do_step[i], last_step[i], done[i], c};
  endfunction

  function automatic logic [7:0] expected(input int i);
    int  it, p;
    bit  run, stp;
    it  = ITERS[i];
    p   = phase[i];
    run = (p >= 2) && (p <= it + 1);
    stp = run && !abort && !(EE && remaining_zero);
    return {p != 0, (p == 1) && !abort, stp, stp && (p == it + 1),
            (p == it + 2) && !abort, 3'(cnt[i])};
  endfunction

  task automatic advance();
    int it, p;
    bit run;
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      it  = ITERS[i];
      p   = phase[i];
      run = (p >= 2) && (p <= it + 1);
      if (reset) begin
        phase[i] = 0;
        cnt[i]   = 0;
      end else if (abort) begin
        phase[i] = 0;
      end else if (p == 0) begin
        phase[i] = start ? 1 : 0;
      end else if (p == 1) begin
        phase[i] = 2;
        cnt[i]   = it - 1;
      end else if (run) begin
        if (EE && remaining_zero) begin
          phase[i] = it + 2;
        end else begin
          cnt[i]   = (it - p > 0) ? it - p : 0;
          phase[i] = p + 1;
        end
      end else begin
        phase[i] = 0;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; abort = 1'b0; remaining_zero = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    start = 1'b1;
    advance();
    idle_inputs();
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (observed(i) !== 8'h00) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %b expected %b", i, observed(i), 8'h00);
      end
    end
    advance();
  endtask

  task automatic test_basic();
    int load_c = -1, first_s = -1, last_s = -1, done_c = -1, steps = 0, busy_n = 0, busy_first = -1;
    for (int c = 0; c < 12; c++) begin
      start = (c == 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (observed(i) !== expected(i)) begin
          miscompares++;
          $display("FAIL basic dut%0d cycle %0d: got %b expected %b", i, c, observed(i), expected(i));
        end
      end
      if (do_load[0]) load_c = c;
      if (do_step[0]) begin steps++; if (first_s < 0) first_s = c; end
      if (last_step[0]) last_s = c;
      if (done[0]) done_c = c;
      if (busy[0]) begin busy_n++; if (busy_first < 0) busy_first = c; end
      advance();
    end
    vectors++;
    if (load_c !== 1 || first_s !== 2 || steps !== 8) begin
      miscompares++;
      $display("FAIL basic_timing: load %0d first_step %0d steps %0d, expected 1 2 8", load_c, first_s, steps);
    end
    vectors++;
    if (last_s !== 9 || done_c !== 10) begin
      miscompares++;
      $display("FAIL basic_end: last_step %0d done %0d, expected 9 10", last_s, done_c);
    end
    vectors++;
    if (busy_first !== 1 || busy_n !== 10) begin
      miscompares++;
      $display("FAIL basic_busy: first %0d cycles %0d, expected 1 10", busy_first, busy_n);
    end
  endtask

  task automatic test_step2();
    logic [1:0] exp_q [$] = '{2'd3, 2'd2, 2'd1, 2'd0};
    logic [1:0] got_q [$];
    int done_c = -1;
    for (int c = 0; c < 12; c++) begin
      start = (c == 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (observed(i) !== expected(i)) begin
          miscompares++;
          $display("FAIL step2 dut%0d cycle %0d: got %b expected %b", i, c, observed(i), expected(i));
        end
      end
      if (do_step[1]) got_q.push_back(count1);
      if (done[1]) done_c = c;
      advance();
    end
    vectors++;
    if (got_q.size() !== 4) begin
      miscompares++;
      $display("FAIL step2_steps: got %0d expected 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL step2_count[%0d]: got %0d expected %0d", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (done_c !== 6) begin
      miscompares++;
      $display("FAIL step2_done: got cycle %0d expected 6", done_c);
    end
  endtask

  task automatic test_abort();
    int steps = 0, loads = 0, dones = 0;
    logic step_at_abort, busy_after;
    for (int c = 0; c < 10; c++) begin
      start = (c <= 4);
      abort = (c == 5);
      #1;
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (observed(i) !== expected(i)) begin
          miscompares++;
          $display("FAIL abort dut%0d cycle %0d: got %b expected %b", i, c, observed(i), expected(i));
        end
      end
      if (do_step[0]) steps++;
      if (do_load[0]) loads++;
      if (done[0]) dones++;
      if (c == 5) step_at_abort = do_step[0];
      if (c == 6) busy_after = busy[0];
      advance();
    end
    abort = 1'b0;
    vectors++;
    if (step_at_abort !== 1'b0 || steps !== 3 || loads !== 1 || dones !== 0) begin
      miscompares++;
      $display("FAIL abort_effect: step@abort %b steps %0d loads %0d dones %0d, expected 0 3 1 0",
               step_at_abort, steps, loads, dones);
    end
    vectors++;
    if (busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b expected 0", busy_after);
    end
  endtask

  task automatic test_reset_mid();
    int steps = 0, done_c = -1;
    for (int c = 0; c < 20; c++) begin
      start = (c == 0) || (c == 6);
      reset = (c == 4);
      #1;
      if (c == 5) begin
        vectors++;
        if (observed(0) !== 8'h00) begin
          miscompares++;
          $display("FAIL reset_mid_clear: got %b expected %b", observed(0), 8'h00);
        end
      end
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (observed(i) !== expected(i)) begin
          miscompares++;
          $display("FAIL reset_mid dut%0d cycle %0d: got %b expected %b", i, c, observed(i), expected(i));
        end
      end
      if (c > 6 && do_step[0]) steps++;
      if (done[0]) done_c = c;
      advance();
    end
    vectors++;
    if (steps !== 8 || done_c !== 16) begin
      miscompares++;
      $display("FAIL reset_mid_restart: steps %0d done %0d, expected 8 16", steps, done_c);
    end
  endtask

  task automatic test_early_exit();
    int steps = 0, done_c = -1;
    int exp_steps = EE ? 2 : 8;
    int exp_done  = EE ? 5 : 10;
    for (int c = 0; c < 14; c++) begin
      start = (c == 0);
      remaining_zero = (c == 4);
      #1;
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (observed(i) !== expected(i)) begin
          miscompares++;
          $display("FAIL early dut%0d cycle %0d: got %b expected %b", i, c, observed(i), expected(i));
        end
      end
      if (do_step[0]) steps++;
      if (done[0]) done_c = c;
      advance();
    end
    remaining_zero = 1'b0;
    vectors++;
    if (steps !== exp_steps || done_c !== exp_done) begin
      miscompares++;
      $display("FAIL early_exit: steps %0d done %0d, expected %0d %0d", steps, done_c, exp_steps, exp_done);
    end
  endtask

  task automatic test_iter1();
    int steps = 0, lasts = 0, done_c = -1;
    for (int c = 0; c < 12; c++) begin
      start = (c == 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (observed(i) !== expected(i)) begin
          miscompares++;
          $display("FAIL iter1 dut%0d cycle %0d: got %b expected %b", i, c, observed(i), expected(i));
        end
      end
      if (do_step[2]) steps++;
      if (do_step[2] && last_step[2] && c == 2) lasts++;
      if (done[2]) done_c = c;
      advance();
    end
    vectors++;
    if (steps !== 1 || lasts !== 1 || done_c !== 3) begin
      miscompares++;
      $display("FAIL iter1_timing: steps %0d last@2 %0d done %0d, expected 1 1 3", steps, lasts, done_c);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset          = ($urandom_range(0, 39) == 0);
      abort          = ($urandom_range(0, 9) == 0);
      start          = ($urandom_range(0, 2) == 0);
      remaining_zero = ($urandom_range(0, 7) == 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (observed(i) !== expected(i)) begin
          miscompares++;
          $display("FAIL random dut%0d cycle %0d: got %b expected %b", i, c, observed(i), expected(i));
        end
      end
      advance();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      phase[i] = 0;
      cnt[i]   = 0;
    end
    test_reset();
    test_basic();
    test_step2();
    test_abort();
    test_reset_mid();
    test_early_exit();
    test_iter1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multiplier_sequencer.md
MULTIPLIER_SEQUENCER -- requirements
Module: multiplier_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, meaning datapath width in bits.
REQ-002 SHALL have parameter STEP, default 1, meaning multiplier bits retired per iteration; legal values 1, 2 and 4; N SHALL be a multiple of STEP.
REQ-003 SHALL have port clock, input, 1 bit, meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, meaning request a multiply; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit, meaning cancel the operation in progress.
REQ-007 SHALL have port remaining_zero, input, 1 bit, meaning the datapath reports that all unretired multiplier bits are zero.
REQ-008 SHALL have port busy, output, 1 bit, meaning the state is not IDLE.
REQ-009 SHALL have port do_load, output, 1 bit, meaning the datapath loads its operands this cycle.
REQ-010 SHALL have port do_step, output, 1 bit, meaning the datapath performs one iteration this cycle.
REQ-011 SHALL have port last_step, output, 1 bit, meaning the current do_step is the final one.
REQ-012 SHALL have port done, output, 1 bit, meaning a one-cycle completion pulse.
REQ-013 SHALL have port count, output, C bits, meaning the remaining iterations minus one.

Function
REQ-014 SHALL define ITER = N/STEP and C = max(1, $clog2(ITER)).
REQ-015 SHALL implement states IDLE, LOAD, RUN and DONE.
REQ-016 SHALL transition IDLE->LOAD when start=1; start SHALL be ignored in every other state.
REQ-017 SHALL assert do_load only in LOAD, preset count to ITER-1 in LOAD, and always go LOAD->RUN.
REQ-018 SHALL assert do_step in each RUN cycle, decrement count after each RUN cycle, and never wrap count below 0.
REQ-019 SHALL assert last_step in RUN when count==0, with a transition RUN->DONE on that cycle.
REQ-020 SHALL produce exactly ITER do_step cycles per unaborted operation; start sampled at edge k gives do_load in cycle k+1, steps in cycles k+2..k+1+ITER, and done in cycle k+2+ITER.
REQ-021 SHALL assert done only in DONE, for one cycle, then return to IDLE; a new start is accepted in the following IDLE cycle, giving no back-to-back overlap.
REQ-022 SHALL make abort=1 in LOAD, RUN or DONE force IDLE next cycle with no done pulse; abort SHALL suppress do_step, do_load, last_step and done in that cycle.
REQ-023 SHALL let abort win when abort and start occur together in IDLE, with the state remaining IDLE.
REQ-024 SHALL handle the edge case ITER=1 with a single RUN cycle in which last_step=1.
REQ-025 SHALL hold count in IDLE and DONE.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, set state=IDLE and count=0 and deassert busy, do_load, do_step, last_step and done, overriding all other inputs including mid-operation.

Configuration
REQ-027 SHALL behave as follows when macro MULTIPLIER_EARLY_EXIT_EN is defined: remaining_zero=1 in a RUN cycle forces do_step=0 and last_step=0 for that cycle, the state goes to DONE next, and count is held.
REQ-028 SHALL, when MULTIPLIER_EARLY_EXIT_EN is undefined, keep the remaining_zero port present but ignore it, so every operation runs exactly ITER steps.

Structure
REQ-029 SHALL place the state enum typedef (multiplier_state_t) and the legal-STEP check helper in package multiplier_pkg.
REQ-030 SHALL instantiate one sub-module, multiplier_iter_counter, a C-bit down-counter with preset, decrement and is_zero outputs and synchronous active-high reset.
REQ-031 SHALL include an elaboration-time check rejecting illegal STEP values or N not a multiple of STEP.

Verification
REQ-032 SHALL cover N=8, STEP=1, start pulse at cycle 0: do_load at cycle 1, do_step in cycles 2-9, last_step at cycle 9, done at cycle 10, busy in cycles 1-10.
REQ-033 SHALL cover N=8, STEP=2: exactly 4 do_step cycles, count sequence 3,2,1,0, and done 6 cycles after start.
REQ-034 SHALL cover N=8, STEP=1 with abort in the 4th RUN cycle: that cycle has no do_step, IDLE follows, no done pulse, busy=0 after; start held high during busy is ignored.
REQ-035 SHALL cover reset asserted in the 3rd RUN cycle: all outputs 0 next cycle and count=0; the next start then gives a full 8-step operation.
REQ-036 SHALL cover, with MULTIPLIER_EARLY_EXIT_EN defined and N=8, STEP=1, remaining_zero=1 in the 3rd RUN cycle: 2 do_step cycles, done the next cycle; without the macro, 8 steps regardless.
REQ-037 SHALL cover N=4, STEP=4 (ITER=1): one RUN cycle with do_step=1 and last_step=1, and done 3 cycles after start.
